// File: rtl/masked_affine_pipe.sv
// Three-share masked RECTANGLE affine layer (forward or inverse per transaction)
// feeding a 2-entry main/skid output buffer. Define MASK_REFRESH_EN to add rnd_a/rnd_b share refresh.

module masked_affine_nib #(
  parameter logic K = 1'b0
) (
  input  logic       inv,
  input  logic [3:0] x,
  output logic [3:0] y
);
  logic [3:0] fwd, bwd;

  // K toggles bits 3 and 2 so that the affine constant lands in exactly one share
  always_comb begin
    fwd[3] = x[2] ^ x[0] ^ K;
    fwd[2] = x[3] ^ x[1] ^ K;
    fwd[1] = x[1];
    fwd[0] = x[3] ^ x[2];
    bwd[3] = x[2] ^ x[1] ^ K;
    bwd[2] = x[0] ^ x[2] ^ x[1] ^ K;
    bwd[1] = x[1];
    bwd[0] = x[3] ^ x[0] ^ x[2] ^ x[1];
    y      = inv ? bwd : fwd;
  end
endmodule

module masked_affine_pipe #(
  parameter int NIB = 16,
  parameter int W   = 4 * NIB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
`ifdef MASK_REFRESH_EN
  input  logic [W-1:0] rnd_a,
  input  logic [W-1:0] rnd_b,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;
  } shares_t;

  state_t                 state_q, state_d;
  shares_t                main_q, skid_q, nxt;
  logic [2:0][W-1:0]      xs, ms;
  logic                   ld_main_new, ld_main_skid, ld_skid;

  assign xs = {x3, x2, x1};

  // share 0 carries the affine constant, shares 1 and 2 get the linear part only
  for (genvar s = 0; s < 3; s++) begin : g_share
    for (genvar n = 0; n < NIB; n++) begin : g_nib
      masked_affine_nib #(.K(s == 0)) u_nib (
        .inv (in_inv),
        .x   (xs[s][4*n +: 4]),
        .y   (ms[s][4*n +: 4])
      );
    end
  end

`ifdef MASK_REFRESH_EN
  assign nxt = '{s1: ms[0] ^ rnd_a, s2: ms[1] ^ rnd_b, s3: ms[2] ^ rnd_a ^ rnd_b};
`else
  assign nxt = '{s1: ms[0], s2: ms[1], s3: ms[2]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (in_valid) state_d = ONE;
      ONE:     if (in_valid && !out_ready) state_d = FULL;
               else if (!in_valid && out_ready) state_d = EMPTY;
      FULL:    if (out_ready) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // in_ready/out_valid come straight from the state register; loads follow from the same decode
  always_comb begin
    in_ready     = (state_q != FULL);
    out_valid    = (state_q != EMPTY);
    ld_main_new  = in_valid && ((state_q == EMPTY) || (state_q == ONE && out_ready));
    ld_main_skid = (state_q == FULL) && out_ready;
    ld_skid      = in_valid && (state_q == ONE) && !out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_new)       main_q <= nxt;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= nxt;
    end
  end

  assign y1 = main_q.s1;
  assign y2 = main_q.s2;
  assign y3 = main_q.s3;
endmodule

// File: tb/tb_masked_affine_pipe.sv
// Directed bench for masked_affine_pipe: vector table, back-pressure, reset flush,
// random forward/inverse round trips, and refresh vectors when MASK_REFRESH_EN is set.

module tb_masked_affine_pipe;
  localparam int NIB = 16;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
  logic [W-1:0] x1 = '0, x2 = '0, x3 = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] y1, y2, y3;
`ifdef MASK_REFRESH_EN
  logic [W-1:0] rnd_a = '0, rnd_b = '0;
`endif
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  masked_affine_pipe #(.NIB(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .x1(x1), .x2(x2), .x3(x3),
`ifdef MASK_REFRESH_EN
    .rnd_a(rnd_a), .rnd_b(rnd_b),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .y1(y1), .y2(y2), .y3(y3)
  );

  typedef struct {
    string        name;
    logic         inv;
    logic [W-1:0] x1, x2, x3, e1, e2, e3;
  } vec_t;

  function automatic logic [W-1:0] rep(input logic [3:0] n);
    return {NIB{n}};
  endfunction

  function automatic vec_t mkv(input string nm, input logic inv,
                               input logic [W-1:0] a, b, c, e1, e2, e3);
    vec_t v;
    v.name = nm; v.inv = inv;
    v.x1 = a; v.x2 = b; v.x3 = c; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // one accepted transaction, returns the shares presented right after the accepting edge
  task automatic xfer(input logic inv, input logic [W-1:0] a, b, c,
                      output logic [W-1:0] r1, r2, r3);
    int t;
    @(negedge clk);
    in_inv = inv; x1 = a; x2 = b; x3 = c; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("xfer_ready_wait", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("latency_valid", W'(out_valid), W'(1));
    r1 = y1; r2 = y2; r3 = y3;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tv[6];
    logic [W-1:0] r1, r2, r3, q1, q2, q3, a, b, c;
    logic         inv;
    int           nx, stale;

    tv[0] = mkv("fwd_zero", 1'b0, '0, '0, '0, rep(4'hC), '0, '0);
    tv[1] = mkv("inv_c", 1'b1, rep(4'hC), '0, '0, '0, '0, '0);
    tv[2] = mkv("fwd_nib", 1'b0, rep(4'hF), rep(4'h1), rep(4'h8), rep(4'hE), rep(4'h8), rep(4'h5));
    tv[3] = mkv("inv_nib", 1'b1, '0, rep(4'h3), rep(4'hA), rep(4'hC), rep(4'hA), rep(4'hE));
    tv[4] = mkv("fwd_mix", 1'b0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h00FF00FF00FF00FF,
                64'hC4A25D3B91F7086E, 64'h2A4CB3D57F19E680, 64'h0022002200220022);
    tv[5] = mkv("inv_mix", 1'b1, 64'hC4A25D3B91F7086E, 64'h2A4CB3D57F19E680, 64'h0022002200220022,
                64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h00FF00FF00FF00FF);

    // reset state
    #12;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_y1", y1, '0);
    chk("rst_y2", y2, '0);
    chk("rst_y3", y3, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    chk("post_rst_out_valid", W'(out_valid), W'(0));

    foreach (tv[i]) begin
      xfer(tv[i].inv, tv[i].x1, tv[i].x2, tv[i].x3, r1, r2, r3);
      chk({tv[i].name, "_y1"}, r1, tv[i].e1);
      chk({tv[i].name, "_y2"}, r2, tv[i].e2);
      chk({tv[i].name, "_y3"}, r3, tv[i].e3);
    end

    // back-pressure: two transfers fill the buffer, third waits, then FIFO drain
    @(negedge clk);
    @(negedge clk);
    chk("drain_empty", W'(out_valid), W'(0));
    out_ready = 1'b0; in_inv = 1'b0; x1 = rep(4'h1); x2 = rep(4'h8); x3 = '0; in_valid = 1'b1;
    nx = 0;
    if (in_valid && in_ready) nx++;
    @(negedge clk);
    chk("bp_ready_one", W'(in_ready), W'(1));
    chk("bp_a_y1", y1, rep(4'h4));
    chk("bp_a_y2", y2, rep(4'h5));
    x1 = rep(4'h2); x2 = '0;
    if (in_valid && in_ready) nx++;
    @(negedge clk);
    chk("bp_ready_full", W'(in_ready), W'(0));
    chk("bp_hold_y1", y1, rep(4'h4));
    x1 = rep(4'h4);
    if (in_valid && in_ready) nx++;
    @(negedge clk);
    chk("bp_ready_full2", W'(in_ready), W'(0));
    chk("bp_hold2_y1", y1, rep(4'h4));
    chk("bp_hold2_y2", y2, rep(4'h5));
    chk("bp_xfer_count", W'(nx), W'(2));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_y1", y1, rep(4'hA));
    chk("bp_b_y2", y2, '0);
    chk("bp_b_ready", W'(in_ready), W'(1));
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_c_y1", y1, rep(4'h5));
    chk("bp_c_valid", W'(out_valid), W'(1));
    @(negedge clk);
    chk("bp_done_empty", W'(out_valid), W'(0));

    // reset while FULL flushes both entries
    out_ready = 1'b0; in_inv = 1'b0; x1 = rep(4'hF); x2 = rep(4'h3); x3 = '0; in_valid = 1'b1;
    @(negedge clk);
    x1 = rep(4'h5);
    @(negedge clk);
    chk("flush_full", W'(in_ready), W'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("flush_valid", W'(out_valid), W'(0));
    chk("flush_y1", y1, '0);
    chk("flush_y2", y2, '0);
    chk("flush_y3", y3, '0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_in_ready", W'(in_ready), W'(1));
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("flush_no_stale", W'(stale), W'(0));
    xfer(1'b0, '0, '0, '0, r1, r2, r3);
    chk("flush_fresh_y1", r1, rep(4'hC));
    chk("flush_fresh_y2", r2, '0);

`ifdef MASK_REFRESH_EN
    rnd_a = '1; rnd_b = '0;
    xfer(1'b0, '0, '0, '0, r1, r2, r3);
    chk("refresh_y1", r1, rep(4'h3));
    chk("refresh_y2", r2, '0);
    chk("refresh_y3", r3, '1);
    chk("refresh_xor", r1 ^ r2 ^ r3, rep(4'hC));
`endif

    // map then opposite map must restore the unmasked value
    for (int k = 0; k < 1000; k++) begin
      inv = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
`ifdef MASK_REFRESH_EN
      rnd_a = {$urandom, $urandom}; rnd_b = {$urandom, $urandom};
`endif
      xfer(inv, a, b, c, r1, r2, r3);
`ifdef MASK_REFRESH_EN
      rnd_a = {$urandom, $urandom}; rnd_b = {$urandom, $urandom};
`endif
      xfer(!inv, r1, r2, r3, q1, q2, q3);
      chk("roundtrip_xor", q1 ^ q2 ^ q3, a ^ b ^ c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/masked_affine_pipe.md
MASKED_AFFINE_PIPE -- requirements
Module: masked_affine_pipe

Interface
REQ-001: Parameter NIB, default 16, is the number of 4-bit nibbles processed in parallel; 16 covers the full 64-bit RECTANGLE state.
REQ-002: Parameter W, default 4*NIB, is the share width in bits; it is derived and SHALL NOT be overridden.
REQ-003: clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004: rst_n  input  1  is the asynchronous, active-low reset.
REQ-005: in_valid  input  1  indicates that the upstream input is valid.
REQ-006: in_ready  output  1  indicates the block can accept an input; it is driven from registered state only.
REQ-007: in_inv  input  1  selects the map per transaction: 0 = forward affine map, 1 = inverse affine map.
REQ-008: x1, x2, x3  input  W each  are the three input shares.
REQ-009: out_valid  output  1  indicates that the output shares are valid.
REQ-010: out_ready  input  1  is the downstream accept signal.
REQ-011: y1, y2, y3  output  W each  are the three output shares.
REQ-012: rnd_a, rnd_b  input  W each  are fresh randomness inputs, present only when MASK_REFRESH_EN is defined.

Function
REQ-013: The block SHALL apply the map per nibble n (bits 4n+3..4n) to each share independently; shares are never combined.
REQ-014: Forward map, per nibble x[3:0] -> y[3:0]:
- y3 = x2^x0^k
- y2 = x3^x1^k
- y1 = x1
- y0 = x3^x2
- k = 1 for share 1 only, k = 0 for shares 2 and 3.
REQ-015: Inverse map, per nibble y[3:0] -> x[3:0]:
- x3 = y2^y1^k
- x2 = y0^y2^y1^k
- x1 = y1
- x0 = y3^y0^y2^y1
- k = 1 for share 1 only, k = 0 for shares 2 and 3.
REQ-016: A transfer occurs on any cycle where in_valid&&in_ready; in_inv, the shares and the randomness are sampled only on a transfer.
REQ-017: The block SHALL contain a 2-entry output buffer (main register plus skid register) with states EMPTY, ONE and FULL.
REQ-018: State transitions:
- push without pop: EMPTY->ONE, ONE->FULL.
- pop without push: FULL->ONE, ONE->EMPTY.
- simultaneous push and pop in ONE: stays ONE.
REQ-019: in_ready = (state != FULL); a push is never accepted while FULL, even if out_ready=1 in the same cycle.
REQ-020: Latency is exactly 1 cycle: data accepted at edge t is presented with out_valid=1 after edge t when the buffer was EMPTY.
REQ-021: Throughput is one transaction per cycle while out_ready=1.
REQ-022: Output ordering is FIFO.
REQ-023: y1, y2, y3 SHALL hold stable while out_valid&&!out_ready.
REQ-024: For every transaction, y1^y2^y3 SHALL equal the unmasked map of x1^x2^x3.

Reset
REQ-025: Asserting rst_n low SHALL immediately force:
- state to EMPTY
- out_valid to 0
- y1, y2, y3 to 0
- in_ready to 1 from the first clock edge after release.
REQ-026: Reset asserted mid-operation SHALL discard all buffered transactions; no stale data reappears after release.

Configuration
REQ-027: With MASK_REFRESH_EN defined, the output shares are refreshed at acceptance: y1 ^= rnd_a, y2 ^= rnd_b, y3 ^= rnd_a^rnd_b.
REQ-028: Refresh leaves the REQ-024 equality intact.
REQ-029: Without MASK_REFRESH_EN, the rnd_a and rnd_b ports are absent and the outputs are the plain map results.

Verification
REQ-030: NIB=16, in_inv=0, x1=x2=x3=0 -> y1=64'hCCCC_CCCC_CCCC_CCCC, y2=y3=0, out_valid one cycle after acceptance.
REQ-031: in_inv=1, x1=64'hCCCC_CCCC_CCCC_CCCC, x2=x3=0 -> y1=y2=y3=0.
REQ-032: 1000 random share triples with random in_inv, each forward result fed back inverse -> y1^y2^y3 equals the original x1^x2^x3 every time.
REQ-033: out_ready=0, in_valid=1 for 3 cycles -> exactly 2 transfers, in_ready=0 from the cycle after the second, outputs stable; then out_ready=1 -> FIFO order, third input accepted.
REQ-034: Buffer FULL, rst_n pulsed low -> out_valid=0 and y*=0 immediately, in_ready=1 after release, no old data emitted.
REQ-035: MASK_REFRESH_EN defined, x*=0, rnd_a=all ones, rnd_b=0, in_inv=0 -> y1=64'h3333_3333_3333_3333, y2=0, y3=all ones, XOR of shares = 64'hCCCC_CCCC_CCCC_CCCC.
